// File: rtl/stitch_fpu_scoreboard_pkg.sv
// rtl/stitch_fpu_scoreboard_pkg.sv - shared types and constants for the FP issue scoreboard
// Contents: NrFpRegs, RISC-V FP opcode constants, acc_addr_e, fp_field_flags_t.
package stitch_fpu_scoreboard_pkg;

    localparam int NrFpRegs = 32;

    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

    typedef enum logic [1:0] {
        ACC_FPU = 2'd0,
        ACC_LSU = 2'd1,
        ACC_DMA = 2'd2,
        ACC_IPU = 2'd3
    } acc_addr_e;

    // Which register fields of an instruction name FP registers.
    typedef struct packed {
        logic rs1_fp;
        logic rs2_fp;
        logic rs3_fp;
        logic rd_fp;
    } fp_field_flags_t;

endpackage

// File: rtl/stitch_fpu_scoreboard_if.sv
// rtl/stitch_fpu_scoreboard_if.sv - offload request stream (valid/ready) with master/slave modports
// Signals: qaddr, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc, qvalid (master->slave), qready (slave->master).
interface stitch_fpu_scoreboard_if #(
    parameter int AddrWidth = 1,
    parameter int DataWidth = 1
);
    import stitch_fpu_scoreboard_pkg::*;

    acc_addr_e              qaddr;
    logic [4:0]             qid;
    logic [31:0]            qdata_op;
    logic [DataWidth-1:0]   qdata_arga;
    logic [DataWidth-1:0]   qdata_argb;
    logic [AddrWidth-1:0]   qdata_argc;
    logic                   qvalid;
    logic                   qready;

    modport master (
        output qaddr, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc, qvalid,
        input  qready
    );

    modport slave (
        input  qaddr, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc, qvalid,
        output qready
    );

endinterface

// File: rtl/stitch_fpu_reg_decode.sv
// rtl/stitch_fpu_reg_decode.sv - combinational decode of which instruction fields are FP registers
// Ports: op_i (32-bit RISC-V instruction) in, flags_o (fp_field_flags_t) out.
module stitch_fpu_reg_decode
    import stitch_fpu_scoreboard_pkg::*;
(
    input  logic [31:0]     op_i,
    output fp_field_flags_t flags_o
);

    // Only opcode and funct5 steer the decode; the register fields are used by the caller.
    logic unused_op_bits;
    assign unused_op_bits = ^op_i[26:7];

    // Conservative: unlisted OP-FP forms keep all fields FP, which can only add stalls.
    always_comb begin
        flags_o = '0;
        case (op_i[6:0])
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                flags_o.rs1_fp = 1'b1;
                flags_o.rs2_fp = 1'b1;
                flags_o.rs3_fp = 1'b1;
                flags_o.rd_fp  = 1'b1;
            end
            OPC_OP_FP: begin
                flags_o.rs1_fp = 1'b1;
                flags_o.rs2_fp = 1'b1;
                flags_o.rd_fp  = 1'b1;
                case (op_i[31:27])
                    // compare, class / mv.x.w, cvt to integer: integer destination
                    5'b10100, 5'b11100, 5'b11000: flags_o.rd_fp = 1'b0;
                    // mv.w.x, cvt from integer: integer source, rs2 field unused
                    5'b11110, 5'b11010: begin
                        flags_o.rs1_fp = 1'b0;
                        flags_o.rs2_fp = 1'b0;
                    end
                    default: ;
                endcase
            end
            OPC_LOAD_FP:  flags_o.rd_fp  = 1'b1;
            OPC_STORE_FP: flags_o.rs2_fp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/stitch_fpu_scoreboard.sv
// rtl/stitch_fpu_scoreboard.sv - FP register hazard scoreboard and one-deep registered issue stage
// Ports: clk_i, rst_ni (async active-low); inp (slave request stream); oup (master request stream);
//        wb_valid_i / wb_rd_i (per-port writeback clears); pending_o (scoreboard); idle_o.
// Option: STITCH_SCOREBOARD_WB_BYPASS_EN masks same-cycle writebacks out of the hazard check.
module stitch_fpu_scoreboard
    import stitch_fpu_scoreboard_pkg::*;
#(
    parameter int AddrWidth = 0,
    parameter int DataWidth = 0,
    parameter int NrWbPorts = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    stitch_fpu_scoreboard_if.slave      inp,
    stitch_fpu_scoreboard_if.master     oup,
    input  logic [NrWbPorts-1:0]        wb_valid_i,
    input  logic [NrWbPorts-1:0][4:0]   wb_rd_i,
    output logic [NrFpRegs-1:0]         pending_o,
    output logic                        idle_o
);

    // A zero width would be meaningless; fall back to one bit so the datapath stays legal.
    localparam int AW = (AddrWidth > 0) ? AddrWidth : 1;
    localparam int DW = (DataWidth > 0) ? DataWidth : 1;
    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;

    fp_field_flags_t        flags;
    logic [4:0]             rs1, rs2, rs3, rd;
    logic [NrFpRegs-1:0]    pending_q, pending_eff, wb_clear_mask, set_mask;
    logic                   hazard, ready, in_hs;

    logic                   out_valid_q;
    acc_addr_e              out_addr_q;
    logic [4:0]             out_id_q;
    logic [31:0]            out_op_q;
    data_t                  out_arga_q, out_argb_q;
    addr_t                  out_argc_q;

    stitch_fpu_reg_decode i_reg_decode (
        .op_i    (inp.qdata_op),
        .flags_o (flags)
    );

    assign rd  = inp.qdata_op[11:7];
    assign rs1 = inp.qdata_op[19:15];
    assign rs2 = inp.qdata_op[24:20];
    assign rs3 = inp.qdata_op[31:27];

    always_comb begin
        wb_clear_mask = '0;
        for (int p = 0; p < NrWbPorts; p++) begin
            if (wb_valid_i[p]) wb_clear_mask[wb_rd_i[p]] = 1'b1;
        end
    end

`ifdef STITCH_SCOREBOARD_WB_BYPASS_EN
    assign pending_eff = pending_q & ~wb_clear_mask;
`else
    assign pending_eff = pending_q;
`endif

    // RAW on any FP source, WAW on an FP destination.
    assign hazard = (flags.rs1_fp & pending_eff[rs1])
                  | (flags.rs2_fp & pending_eff[rs2])
                  | (flags.rs3_fp & pending_eff[rs3])
                  | (flags.rd_fp  & pending_eff[rd]);

    assign ready     = ~hazard & (~out_valid_q | oup.qready);
    assign inp.qready = ready;
    assign in_hs     = inp.qvalid & ready;

    assign set_mask = (in_hs & flags.rd_fp) ? (NrFpRegs'(1) << rd) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= ACC_FPU;
            out_id_q    <= '0;
            out_op_q    <= '0;
            out_arga_q  <= '0;
            out_argb_q  <= '0;
            out_argc_q  <= '0;
        end else begin
            // Clear first, then set: a set of the same register wins.
            pending_q <= (pending_q & ~wb_clear_mask) | set_mask;
            if (in_hs) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= inp.qaddr;
                out_id_q    <= inp.qid;
                out_op_q    <= inp.qdata_op;
                out_arga_q  <= inp.qdata_arga;
                out_argb_q  <= inp.qdata_argb;
                out_argc_q  <= inp.qdata_argc;
            end else if (oup.qready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign oup.qvalid     = out_valid_q;
    assign oup.qaddr      = out_addr_q;
    assign oup.qid        = out_id_q;
    assign oup.qdata_op   = out_op_q;
    assign oup.qdata_arga = out_arga_q;
    assign oup.qdata_argb = out_argb_q;
    assign oup.qdata_argc = out_argc_q;

    assign pending_o = pending_q;
    assign idle_o    = (pending_q == '0) & ~out_valid_q;

    // A writeback to a register that is not pending points at a lost or duplicated result.
    for (genvar p = 0; p < NrWbPorts; p++) begin : g_wb_chk
        wb_to_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
            wb_valid_i[p] |-> pending_q[wb_rd_i[p]]);
    end

endmodule
